// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one I2C byte-write engine with NACK retry and hang timeout
module i2c_cmd_arbiter #(
    parameter int N_REQ       = 3,
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_GAP   = 1000,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [N_REQ-1:0]      req,
    input  logic [24*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      err,
    output logic                  eng_go,
    output logic [23:0]           eng_data,
    input  logic                  eng_done,
    input  logic                  eng_nack,
    output logic                  busy,
    output logic [2:0]            grant_idx
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int GW = $clog2(RETRY_GAP + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    // eng_go also stays low during ISSUE, so GAP itself lasts one cycle less than the gap
    localparam logic [GW-1:0] GAP_LAST  = GW'(RETRY_GAP > 1 ? RETRY_GAP - 2 : 0);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [2:0]    LAST_IDX  = 3'(N_REQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_FINISH} state_t;

    state_t            state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        rr_q, rr_d;
    logic [23:0]       data_q, data_d;
    logic              go_q, go_d;
    logic              busy_q, busy_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [N_REQ-1:0]  err_q, err_d;
    logic [3:0]        retry_q, retry_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [GW-1:0]     gap_q, gap_d;

    logic [7:0]        req8;
    logic [23:0]       slot [8];
    logic              win_found;
    logic [2:0]        win_idx;
    logic [N_REQ-1:0]  sel;

    // requests and commands padded to eight slots so a 3-bit index selects exactly
    assign req8 = 8'(req);
    for (genvar g = 0; g < 8; g++) begin : g_slot
        if (g < N_REQ) begin : g_on
            assign slot[g] = req_data[24*g +: 24];
        end else begin : g_off
            assign slot[g] = '0;
        end
    end

    assign sel = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

    // round-robin search starting at rr_q; first set request wins
    always_comb begin
        logic [2:0] k;
        win_found = 1'b0;
        win_idx   = '0;
        k         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = 3'((int'(rr_q) + i) % N_REQ);
            if (!win_found && req8[k]) begin
                win_found = 1'b1;
                win_idx   = k;
            end
        end
    end

    // next-state and registered outputs of the transaction sequencer
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        data_d  = data_q;
        go_d    = go_q;
        busy_d  = busy_q;
        done_d  = '0;
        err_d   = '0;
        retry_d = retry_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    data_d  = slot[win_idx];
                    retry_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                go_d    = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done && !eng_nack) begin
                    go_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = sel;
                    state_d = S_FINISH;
                end else if (eng_done && retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 4'd1;
                    go_d    = 1'b0;
                    gap_d   = '0;
                    state_d = RETRY_GAP > 1 ? S_GAP : S_ISSUE;
                end else if (eng_done || tmo_q == TMO_LAST) begin
                    go_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = sel;
                    err_d   = sel;
                    state_d = S_FINISH;
                end else begin
                    tmo_d = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
                end
            end
            S_GAP: begin
                gap_d   = gap_q + 1'b1;
                state_d = gap_q == GAP_LAST ? S_ISSUE : S_GAP;
            end
            S_FINISH: begin
                rr_d    = grant_q == LAST_IDX ? 3'd0 : grant_q + 3'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state register; reset aborts any transfer without a completion pulse
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            data_q  <= '0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            retry_q <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
        end
    end

    assign eng_go    = go_q;
    assign eng_data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign grant_idx = grant_q;
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: scoreboard bench for the I2C command arbiter with a scripted engine
module tb_i2c_cmd_arbiter;
    localparam logic [23:0] D0 = 24'h729803;
    localparam logic [23:0] D1 = 24'h4A1B2C;
    localparam logic [23:0] D2 = 24'h3400C5;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic [2:0]  req = '0;
    logic [71:0] req_data;
    logic [2:0]  done, err;
    logic        eng_go;
    logic [23:0] eng_data;
    logic        eng_done = 1'b0;
    logic        eng_nack = 1'b0;
    logic        busy;
    logic [2:0]  grant_idx;

    assign req_data = {D2, D1, D0};

    i2c_cmd_arbiter #(.N_REQ(3), .MAX_RETRY(3), .RETRY_GAP(10), .TIMEOUT_CYC(100)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .req(req), .req_data(req_data),
        .done(done), .err(err), .eng_go(eng_go), .eng_data(eng_data),
        .eng_done(eng_done), .eng_nack(eng_nack), .busy(busy), .grant_idx(grant_idx)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int fall_t = 0;

    typedef struct packed {logic [2:0] g; logic [23:0] d;} go_t;
    typedef struct packed {logic [2:0] dn; logic [2:0] er;} dn_t;
    go_t go_q[$];
    dn_t dn_q[$];
    go_t ge;
    dn_t de;
    logic prev_go = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic exp_go(input logic [2:0] g, input logic [23:0] d);
        go_q.push_back('{g: g, d: d});
    endtask

    task automatic exp_dn(input logic [2:0] dn, input logic [2:0] er);
        dn_q.push_back('{dn: dn, er: er});
    endtask

    task automatic abort_run(input string why);
        n_chk++;
        $display("FAIL %s: wait bound expired", why);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "bench aborted");
    endtask

    // monitor: every engine launch and every completion is matched against the scoreboard
    always @(negedge iCLK) begin
        if (eng_go && !prev_go) begin
            if (go_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected eng_go: grant=%0d data=%h, none expected", grant_idx, eng_data);
            end else begin
                ge = go_q.pop_front();
                chk("launch grant_idx", 32'(grant_idx), 32'(ge.g));
                chk("launch eng_data", 32'(eng_data), 32'(ge.d));
            end
        end
        if (done != 0 || err != 0) begin
            if (dn_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected completion: done=%b err=%b, none expected", done, err);
            end else begin
                de = dn_q.pop_front();
                chk("completion done", 32'(done), 32'(de.dn));
                chk("completion err", 32'(err), 32'(de.er));
            end
        end
        prev_go <= eng_go;
    end

    task automatic wait_go(output int t);
        int n;
        n = 0;
        while (!eng_go && n < 300) begin
            @(negedge iCLK);
            n++;
        end
        if (!eng_go) abort_run("eng_go rise");
        t = cyc;
    endtask

    task automatic serve(input int dly, input logic nack, output int t);
        wait_go(t);
        repeat (dly) @(negedge iCLK);
        eng_done = 1'b1;
        eng_nack = nack;
        @(negedge iCLK);
        eng_done = 1'b0;
        eng_nack = 1'b0;
        chk("eng_go low after eng_done", 32'(eng_go), 32'd0);
        fall_t = cyc;
    endtask

    task automatic pulse_reset();
        iRST_N = 1'b0;
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
    endtask

    logic [2:0] rr_grant [4] = '{3'd0, 3'd1, 3'd2, 3'd0};

    initial begin
        int t, t0, f, n;
        repeat (3) @(negedge iCLK);
        chk("reset eng_go", 32'(eng_go), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset grant_idx", 32'(grant_idx), 32'd0);
        chk("reset eng_data", 32'(eng_data), 32'd0);
        iRST_N = 1'b1;
        @(negedge iCLK);
        exp_go(3'd0, D0);
        exp_dn(3'b001, 3'b000);
        req = 3'b001;
        t0 = cyc;
        wait_go(t);
        chk("req to eng_go latency", 32'(t - t0), 32'd2);
        chk("busy while granted", 32'(busy), 32'd1);
        serve(50, 1'b0, t);
        chk("single done one cycle after eng_done", 32'(done), 32'b001);
        chk("single err", 32'(err), 32'b000);
        req = 3'b000;
        repeat (3) @(negedge iCLK);
        chk("busy after single", 32'(busy), 32'd0);
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            exp_go(rr_grant[i], rr_grant[i] == 3'd0 ? D0 : rr_grant[i] == 3'd1 ? D1 : D2);
            exp_dn(3'b001 << rr_grant[i], 3'b000);
        end
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            serve(4, 1'b0, t);
            chk("round robin done", 32'(done), 32'(3'b001 << rr_grant[i]));
        end
        req = 3'b000;
        repeat (3) @(negedge iCLK);
        repeat (3) exp_go(3'd1, D1);
        exp_dn(3'b010, 3'b000);
        req = 3'b010;
        serve(3, 1'b1, t);
        f = fall_t;
        serve(3, 1'b1, t);
        chk("first retry gap", 32'(t - f), 32'd10);
        f = fall_t;
        serve(3, 1'b0, t);
        chk("second retry gap", 32'(t - f), 32'd10);
        chk("retry done", 32'(done), 32'b010);
        chk("retry err", 32'(err), 32'b000);
        req = 3'b000;
        repeat (3) @(negedge iCLK);
        repeat (4) exp_go(3'd0, D0);
        exp_dn(3'b001, 3'b001);
        exp_go(3'd1, D1);
        exp_dn(3'b010, 3'b000);
        req = 3'b011;
        repeat (4) serve(2, 1'b1, t);
        chk("exhaustion done", 32'(done), 32'b001);
        chk("exhaustion err", 32'(err), 32'b001);
        req = 3'b010;
        serve(2, 1'b0, t);
        chk("next requester done", 32'(done), 32'b010);
        req = 3'b000;
        repeat (3) @(negedge iCLK);
        exp_go(3'd2, D2);
        exp_dn(3'b100, 3'b100);
        req = 3'b100;
        wait_go(t);
        n = 0;
        while (eng_go && n < 300) begin
            @(negedge iCLK);
            n++;
        end
        if (eng_go) abort_run("timeout eng_go fall");
        chk("timeout eng_go high cycles", 32'(cyc - t), 32'd100);
        chk("timeout done", 32'(done), 32'b100);
        chk("timeout err", 32'(err), 32'b100);
        req = 3'b000;
        @(negedge iCLK);
        @(negedge iCLK);
        eng_done = 1'b1;
        @(negedge iCLK);
        eng_done = 1'b0;
        repeat (3) @(negedge iCLK);
        chk("late eng_done ignored eng_go", 32'(eng_go), 32'd0);
        chk("late eng_done ignored busy", 32'(busy), 32'd0);
        exp_go(3'd0, D0);
        req = 3'b001;
        wait_go(t);
        repeat (5) @(negedge iCLK);
        #2 iRST_N = 1'b0;
        #1;
        chk("abort eng_go", 32'(eng_go), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort err", 32'(err), 32'd0);
        req = 3'b010;
        @(negedge iCLK);
        @(negedge iCLK);
        exp_go(3'd1, D1);
        exp_dn(3'b010, 3'b000);
        iRST_N = 1'b1;
        serve(4, 1'b0, t);
        chk("post-reset grant done", 32'(done), 32'b010);
        req = 3'b000;
        repeat (5) @(negedge iCLK);
        chk("launches left unmatched", 32'(go_q.size()), 32'd0);
        chk("completions left unmatched", 32'(dn_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
